framebuffer_dbuf: RTL and testbench
===================================

Name: framebuffer_dbuf

Overview:
Double-buffered framebuffer, successor to the single-page framebuffer. Holds two pages of DEPTH_A words, each DATA_WIDTH_A bits wide. CPU port A gets byte-masked read/write access to the back page. Video port B reads the front page at a narrower DATA_WIDTH_B granularity. Adds page flip synchronised to vsync and a hardware clear engine that fills the back page.

Parameters:
DEPTH_A, 4096, words per page on port A
DATA_WIDTH_A, 16, port A word width; multiple of 8
DATA_WIDTH_B, 8, port B word width; multiple of 8; DATA_WIDTH_A/DATA_WIDTH_B must be a power of two
LANES, DATA_WIDTH_A/8, derived byte-lane count
RATIO, DATA_WIDTH_A/DATA_WIDTH_B, derived
ADDRESS_WIDTH_A, $clog2(DEPTH_A), derived
ADDRESS_WIDTH_B, $clog2(DEPTH_A*RATIO), derived

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
wr_a  in  1  write strobe, port A
mask_a  in  LANES  byte-lane write enables; bit i maps to bits [8i+7:8i]
addr_a  in  ADDRESS_WIDTH_A  word address within back page
data_a  in  DATA_WIDTH_A  write data
q_a  out  DATA_WIDTH_A  read data, back page
ready_a  out  1  high when port A accesses are accepted
addr_b  in  ADDRESS_WIDTH_B  narrow-word address within front page
q_b  out  DATA_WIDTH_B  read data, front page
flip_req  in  1  pulse: request page swap
vsync  in  1  one-cycle strobe at start of vertical blank
flip_pending  out  1  flip requested, not yet performed
flip_done  out  1  one-cycle pulse in the cycle after the swap
clear_req  in  1  pulse: fill back page with clear_value
clear_value  in  DATA_WIDTH_A  fill word, sampled with clear_req
busy  out  1  clear engine active

Behaviour:
- Storage: 2*DEPTH_A words, split into LANES byte-wide arrays. Page bit is the MSB of the physical address. Memory contents are not reset.
- Reset values: front_page=0, back_page=1, q_a=0, q_b=0, flip_pending=0, flip_done=0, busy=0, ready_a=1, FSM=IDLE.
- Port A:
  - Physical address = {back_page, addr_a}.
  - Read latency 1 cycle; q_a returns the old data on a same-address write (read-before-write).
  - Writes honour mask_a. Writes with mask_a=0 do nothing.
- Port B:
  - Physical word = {front_page, addr_b[ADDRESS_WIDTH_B-1:log2 RATIO]}.
  - Lane select = addr_b low log2(RATIO) bits, with lane 0 = LSBs. Register the select alongside the address.
  - Latency 1 cycle. RATIO=1 means no lane select.
- Flip:
  - pend_next = flip_pending | flip_req.
  - The swap occurs in a cycle where pend_next & vsync & !busy. A flip_req in the same cycle as vsync qualifies.
  - The swap exchanges front_page and back_page at the clock edge and clears flip_pending.
  - flip_done pulses in the following cycle.
  - In the swap cycle, port A/B accesses still use the old page mapping; the new mapping applies from the next cycle.
  - Repeated flip_req while pending has no extra effect.
  - A vsync while busy defers the swap to the next vsync after clear completes.
- Clear FSM: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req: latch clear_value, counter=0, busy=1, ready_a=0.
  - CLEAR: each cycle writes the latched value to all lanes at {back_page, counter}, then counter++.
  - When the write at counter==DEPTH_A-1 completes, return to IDLE. busy and ready_a are restored the next cycle.
  - Total busy time is exactly DEPTH_A cycles.
  - clear_req while busy is ignored.
  - While ready_a=0, port A writes are dropped and q_a holds its last value. Port B is unaffected.
  - clear_req and flip in the same cycle: the flip is evaluated first (it sees !busy), then the clear targets the new back page.
- Reset mid-clear: FSM goes to IDLE with busy=0. The page is left partially filled.

Optional Feature:
FB_CLEAR_EN
- Defined: clear engine present as described above.
- Undefined: no FSM or counter. clear_req and clear_value are ignored, busy is tied 0, ready_a is tied 1, and flips are never deferred by busy.

Decomposition:
- Package fb_pkg: clear FSM state enum (FB_IDLE, FB_CLEAR) and a lane-select helper function.
- One natural sub-module: fb_clear_engine (FSM, counter, value latch, busy). It drives a write override into the RAM port-A mux.
- Page registers and RAM stay in the top module.

Test Plan:
- Byte mask: DEPTH_A=16, DATA_WIDTH_A=16, DATA_WIDTH_B=8. Write addr_a=3, data 0xABCD, mask 2'b11, then 0x1200 with mask 2'b10 -> q_a=0x12CD one cycle after a read of addr 3.
- Page isolation: after reset, write addr_a=5 = 0x1234 (back page 1). Read addr_b=10 -> q_b from page 0, not 0x34. After the flip, addr_b=10 -> 0x34 and addr_b=11 -> 0x12.
- Flip timing: flip_req at cycle 10, vsync at cycle 20 -> flip_pending high cycles 11-20, swap at edge of cycle 20, flip_done high cycle 21 only. flip_req together with vsync at cycle 30 -> flip_done at cycle 31.
- Clear: clear_req with 0xBEEF -> busy high exactly 16 cycles and ready_a=0. A wr_a during busy leaves memory unchanged. Afterwards all 16 back-page words read 0xBEEF; the front page is untouched.
- Flip deferred: pending flip with vsync during busy -> no swap, flip_pending stays 1. Swap occurs at the first vsync after busy falls.
- Reset mid-clear: assert reset at clear cycle 5 -> busy=0, ready_a=1 next cycle, words 0-4 hold the clear value and words 5-15 keep their old contents. With FB_CLEAR_EN undefined, clear_req -> busy stays 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered framebuffer.
//   fb_state_e  : clear-engine state encoding (FB_IDLE, FB_CLEAR)
//   lane_offset : bit offset of a narrow lane inside a wide word
package fb_pkg;

  typedef enum logic {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_e;

  // Lane 0 occupies the least significant bits of the wide word.
  function automatic int unsigned lane_offset(input int unsigned sel,
                                              input int unsigned width);
    return sel * width;
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Hardware clear engine: fills every word of the back page with a latched
// value, one word per cycle, for exactly DEPTH_A cycles.
// Only built when FB_CLEAR_EN is defined.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   clear_req         : pulse, start a fill (ignored while busy)
//   clear_value       : fill word, sampled with clear_req
//   busy              : fill in progress
//   ready             : inverse of busy; gates CPU port A accesses
//   clr_we            : write override into the RAM port-A mux
//   clr_addr/clr_data : word address within the back page / fill word
`ifdef FB_CLEAR_EN
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int DEPTH_A         = 4096,
  parameter int DATA_WIDTH_A    = 16,
  parameter int ADDRESS_WIDTH_A = $clog2(DEPTH_A)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_req,
  input  logic [DATA_WIDTH_A-1:0]    clear_value,
  output logic                       busy,
  output logic                       ready,
  output logic                       clr_we,
  output logic [ADDRESS_WIDTH_A-1:0] clr_addr,
  output logic [DATA_WIDTH_A-1:0]    clr_data
);

  localparam logic [ADDRESS_WIDTH_A-1:0] LAST_WORD = ADDRESS_WIDTH_A'(DEPTH_A - 1);

  fb_state_e                  state_q, state_d;
  logic [ADDRESS_WIDTH_A-1:0] count_q, count_d;
  logic [DATA_WIDTH_A-1:0]    value_q, value_d;
  logic                       busy_q,  busy_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    count_d = count_q;
    value_d = value_q;
    busy_d  = busy_q;
    unique case (state_q)
      FB_IDLE: begin
        if (clear_req) begin
          state_d = FB_CLEAR;
          count_d = '0;
          value_d = clear_value;
          busy_d  = 1'b1;
        end
      end
      FB_CLEAR: begin
        count_d = count_q + 1'b1;
        // The write at the last word happens on this edge; busy drops after it.
        if (count_q == LAST_WORD) begin
          state_d = FB_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = FB_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset mid-fill abandons the page partially written.
      state_q <= FB_IDLE;
      count_q <= '0;
      value_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      state_q <= state_d;
      count_q <= count_d;
      value_q <= value_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign ready    = ~busy_q;
  assign clr_we   = (state_q == FB_CLEAR);
  assign clr_addr = count_q;
  assign clr_data = value_q;

endmodule
`endif

// File: rtl/framebuffer_dbuf.sv
// Double-buffered framebuffer. Two pages of DEPTH_A words; the CPU (port A)
// has byte-masked read/write access to the back page, video (port B) reads
// the front page in narrower DATA_WIDTH_B slices. Pages swap on vsync after
// a flip request. Optional clear engine (macro FB_CLEAR_EN) fills the back
// page; without it clear_req/clear_value are ignored, busy=0, ready_a=1.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   wr_a, mask_a, addr_a,
//   data_a, q_a, ready_a       : CPU port, back page, 1-cycle read latency
//   addr_b, q_b                : video port, front page, 1-cycle latency
//   flip_req, vsync            : flip request pulse, vertical-blank strobe
//   flip_pending, flip_done    : flip waiting / pulse in cycle after swap
//   clear_req, clear_value,
//   busy                       : clear engine control and status
module framebuffer_dbuf
  import fb_pkg::*;
#(
  parameter  int DEPTH_A         = 4096,
  parameter  int DATA_WIDTH_A    = 16,
  parameter  int DATA_WIDTH_B    = 8,
  localparam int LANES           = DATA_WIDTH_A / 8,
  localparam int RATIO           = DATA_WIDTH_A / DATA_WIDTH_B,
  localparam int ADDRESS_WIDTH_A = $clog2(DEPTH_A),
  localparam int ADDRESS_WIDTH_B = $clog2(DEPTH_A * RATIO)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_a,
  input  logic [LANES-1:0]           mask_a,
  input  logic [ADDRESS_WIDTH_A-1:0] addr_a,
  input  logic [DATA_WIDTH_A-1:0]    data_a,
  output logic [DATA_WIDTH_A-1:0]    q_a,
  output logic                       ready_a,
  input  logic [ADDRESS_WIDTH_B-1:0] addr_b,
  output logic [DATA_WIDTH_B-1:0]    q_b,
  input  logic                       flip_req,
  input  logic                       vsync,
  output logic                       flip_pending,
  output logic                       flip_done,
  input  logic                       clear_req,
  input  logic [DATA_WIDTH_A-1:0]    clear_value,
  output logic                       busy
);

  localparam int SEL_W  = $clog2(RATIO);
  localparam int SEL_WQ = (SEL_W == 0) ? 1 : SEL_W;
  localparam int PHYS_W = ADDRESS_WIDTH_A + 1;

  logic              front_page_q,   front_page_d;
  logic              back_page_q,    back_page_d;
  logic              flip_pending_q, flip_pending_d;
  logic              flip_done_q,    flip_done_d;
  logic [SEL_WQ-1:0] sel_b_q,        sel_b_d;
  logic              pend_next, swap;

  logic [PHYS_W-1:0]       phys_a, phys_b, wr_addr;
  logic [DATA_WIDTH_A-1:0] wr_data, q_a_word, word_b;
  logic                    clr_we;

`ifdef FB_CLEAR_EN
  logic [ADDRESS_WIDTH_A-1:0] clr_addr;
  logic [DATA_WIDTH_A-1:0]    clr_data;

  fb_clear_engine #(
    .DEPTH_A         (DEPTH_A),
    .DATA_WIDTH_A    (DATA_WIDTH_A),
    .ADDRESS_WIDTH_A (ADDRESS_WIDTH_A)
  ) u_clear_engine (
    .clk         (clk),
    .reset       (reset),
    .clear_req   (clear_req),
    .clear_value (clear_value),
    .busy        (busy),
    .ready       (ready_a),
    .clr_we      (clr_we),
    .clr_addr    (clr_addr),
    .clr_data    (clr_data)
  );

  // The fill owns the write port while active; the back page cannot change
  // mid-fill because flips are held off by busy.
  assign wr_addr = clr_we ? {back_page_q, clr_addr} : phys_a;
  assign wr_data = clr_we ? clr_data : data_a;
`else
  logic unused_clear;
  assign unused_clear = ^{clear_req, clear_value};
  assign busy    = 1'b0;
  assign ready_a = 1'b1;
  assign clr_we  = 1'b0;
  assign wr_addr = phys_a;
  assign wr_data = data_a;
`endif

  assign phys_a = {back_page_q, addr_a};
  assign phys_b = {front_page_q, addr_b[ADDRESS_WIDTH_B-1:SEL_W]};

  // Flip control: a request in the same cycle as vsync qualifies; busy
  // holds the request pending until a later vsync.
  always_comb begin
    pend_next      = flip_pending_q | flip_req;
    swap           = pend_next & vsync & ~busy;
    front_page_d   = swap ? back_page_q  : front_page_q;
    back_page_d    = swap ? front_page_q : back_page_q;
    flip_pending_d = pend_next & ~swap;
    flip_done_d    = swap;
    sel_b_d        = (RATIO == 1) ? '0 : addr_b[SEL_WQ-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_page_q   <= 1'b0;
      back_page_q    <= 1'b1;
      flip_pending_q <= 1'b0;
      flip_done_q    <= 1'b0;
      sel_b_q        <= '0;
    end else begin
      front_page_q   <= front_page_d;
      back_page_q    <= back_page_d;
      flip_pending_q <= flip_pending_d;
      flip_done_q    <= flip_done_d;
      sel_b_q        <= sel_b_d;
    end
  end

  // One byte-wide RAM per lane so mask_a maps directly to write enables.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] mem [2*DEPTH_A];
    logic [7:0] q_a_lane, q_b_lane;
    logic       we;

    assign we = clr_we | (wr_a & ready_a & mask_a[i]);

    // NOTE: the storage array has no reset; only the read registers do.
    always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data[8*i +: 8];
    end

    // Reads see pre-write contents on a same-address write; q_a holds
    // while the clear engine owns the port.
    always_ff @(posedge clk) begin
      if (reset) begin
        q_a_lane <= '0;
        q_b_lane <= '0;
      end else begin
        if (ready_a) q_a_lane <= mem[phys_a];
        q_b_lane <= mem[phys_b];
      end
    end

    assign q_a_word[8*i +: 8] = q_a_lane;
    assign word_b[8*i +: 8]   = q_b_lane;
  end

  always_comb begin
    q_b = word_b[DATA_WIDTH_B-1:0];
    for (int l = 1; l < RATIO; l++) begin
      if (sel_b_q == SEL_WQ'(l)) q_b = word_b[lane_offset(l, DATA_WIDTH_B) +: DATA_WIDTH_B];
    end
  end

  assign q_a          = q_a_word;
  assign flip_pending = flip_pending_q;
  assign flip_done    = flip_done_q;

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Directed bench for framebuffer_dbuf with DEPTH_A=16, 16-bit port A and
// 8-bit port B. Clear-engine scenarios run when FB_CLEAR_EN is defined;
// otherwise the bench confirms the engine is absent.
module tb_framebuffer_dbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_a;
  logic [1:0]  mask_a;
  logic [3:0]  addr_a;
  logic [15:0] data_a;
  logic [15:0] q_a;
  logic        ready_a;
  logic [4:0]  addr_b;
  logic [7:0]  q_b;
  logic        flip_req;
  logic        vsync;
  logic        flip_pending;
  logic        flip_done;
  logic        clear_req;
  logic [15:0] clear_value;
  logic        busy;

  int checks = 0;
  int errors = 0;

  framebuffer_dbuf #(
    .DEPTH_A      (16),
    .DATA_WIDTH_A (16),
    .DATA_WIDTH_B (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_a         (wr_a),
    .mask_a       (mask_a),
    .addr_a       (addr_a),
    .data_a       (data_a),
    .q_a          (q_a),
    .ready_a      (ready_a),
    .addr_b       (addr_b),
    .q_b          (q_b),
    .flip_req     (flip_req),
    .vsync        (vsync),
    .flip_pending (flip_pending),
    .flip_done    (flip_done),
    .clear_req    (clear_req),
    .clear_value  (clear_value),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    addr_a = a; data_a = d; mask_a = m; wr_a = 1'b1;
    tick();
    wr_a = 1'b0; mask_a = 2'b00;
  endtask

  task automatic do_flip();
    flip_req = 1'b1; vsync = 1'b1;
    tick();
    flip_req = 1'b0; vsync = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (q_a !== 16'h0000) begin errors++; $display("FAIL reset_q_a got %h exp 0000", q_a); end
    checks++; if (q_b !== 8'h00) begin errors++; $display("FAIL reset_q_b got %h exp 00", q_b); end
    checks++; if (flip_pending !== 1'b0) begin errors++; $display("FAIL reset_flip_pending got %b exp 0", flip_pending); end
    checks++; if (flip_done !== 1'b0) begin errors++; $display("FAIL reset_flip_done got %b exp 0", flip_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a got %b exp 1", ready_a); end
  endtask

  task automatic test_byte_mask();
    write_a(4'd3, 16'hABCD, 2'b11);
    write_a(4'd3, 16'h1200, 2'b10);
    addr_a = 4'd3;
    tick();
    checks++; if (q_a !== 16'h12CD) begin errors++; $display("FAIL byte_mask got %h exp 12cd", q_a); end
    write_a(4'd3, 16'hFFFF, 2'b00);
    tick();
    checks++; if (q_a !== 16'h12CD) begin errors++; $display("FAIL mask_zero got %h exp 12cd", q_a); end
    // Same-address write and read: old data first, new data next cycle.
    write_a(4'd3, 16'h0000, 2'b11);
    checks++; if (q_a !== 16'h12CD) begin errors++; $display("FAIL read_before_write got %h exp 12cd", q_a); end
    tick();
    checks++; if (q_a !== 16'h0000) begin errors++; $display("FAIL write_then_read got %h exp 0000", q_a); end
  endtask

  task automatic test_page_isolation();
    write_a(4'd5, 16'h1234, 2'b11);     // page 1 (back)
    addr_a = 4'd5;
    do_flip();                           // read in swap cycle uses old back page
    checks++; if (q_a !== 16'h1234) begin errors++; $display("FAIL swap_cycle_q_a got %h exp 1234", q_a); end
    write_a(4'd5, 16'h5678, 2'b11);     // page 0 (now back)
    addr_b = 5'd10; tick();
    checks++; if (q_b !== 8'h34) begin errors++; $display("FAIL front1_lo got %h exp 34", q_b); end
    addr_b = 5'd11; tick();
    checks++; if (q_b !== 8'h12) begin errors++; $display("FAIL front1_hi got %h exp 12", q_b); end
    addr_a = 4'd5; tick();
    checks++; if (q_a !== 16'h5678) begin errors++; $display("FAIL back0_q_a got %h exp 5678", q_a); end
    do_flip();
    addr_b = 5'd10; tick();
    checks++; if (q_b !== 8'h78) begin errors++; $display("FAIL front0_lo got %h exp 78", q_b); end
    addr_b = 5'd11; tick();
    checks++; if (q_b !== 8'h56) begin errors++; $display("FAIL front0_hi got %h exp 56", q_b); end
    addr_a = 4'd5; tick();
    checks++; if (q_a !== 16'h1234) begin errors++; $display("FAIL back1_q_a got %h exp 1234", q_a); end
  endtask

  task automatic test_flip_timing();
    logic exp_p, exp_d;
    // Step k drives cycle k; after the tick the bench observes cycle k+1.
    for (int k = 0; k <= 12; k++) begin
      flip_req = (k == 0) || (k == 3);
      vsync    = (k == 10) || (k == 12);
      tick();
      exp_p = (k <= 9);
      exp_d = (k == 10);
      checks++; if (flip_pending !== exp_p) begin errors++; $display("FAIL flip_pending cyc%0d got %b exp %b", k + 1, flip_pending, exp_p); end
      checks++; if (flip_done !== exp_d) begin errors++; $display("FAIL flip_done cyc%0d got %b exp %b", k + 1, flip_done, exp_d); end
    end
    flip_req = 1'b0; vsync = 1'b0;
    do_flip();
    checks++; if (flip_done !== 1'b1) begin errors++; $display("FAIL same_cycle_done got %b exp 1", flip_done); end
    checks++; if (flip_pending !== 1'b0) begin errors++; $display("FAIL same_cycle_pending got %b exp 0", flip_pending); end
    tick();
    checks++; if (flip_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b exp 0", flip_done); end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    for (int i = 0; i < 16; i++) write_a(4'(i), 16'h1000 + 16'(i), 2'b11);
    do_flip();                           // pattern now front (page 1), back is page 0
    addr_a = 4'd5; tick();
    checks++; if (q_a !== 16'h5678) begin errors++; $display("FAIL pre_clear_q_a got %h exp 5678", q_a); end
    clear_value = 16'hBEEF; clear_req = 1'b1;
    tick();
    clear_req = 1'b0; addr_a = 4'd9;
    for (int b = 1; b <= 16; b++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy cyc%0d got %b exp 1", b, busy); end
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL clear_ready cyc%0d got %b exp 0", b, ready_a); end
      if (b == 2) begin
        checks++; if (q_a !== 16'h5678) begin errors++; $display("FAIL q_a_hold got %h exp 5678", q_a); end
      end
      if (b == 4) begin clear_req = 1'b1; clear_value = 16'h1111; end
      if (b == 10) begin addr_a = 4'd0; data_a = 16'h5555; mask_a = 2'b11; wr_a = 1'b1; end
      tick();
      clear_req = 1'b0; wr_a = 1'b0; mask_a = 2'b00;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_end_busy got %b exp 0", busy); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL clear_end_ready got %b exp 1", ready_a); end
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i); tick();
      checks++; if (q_a !== 16'hBEEF) begin errors++; $display("FAIL cleared_word%0d got %h exp beef", i, q_a); end
    end
    for (int i = 0; i < 16; i++) begin
      addr_b = 5'(2 * i); tick();
      checks++; if (q_b !== 8'(i)) begin errors++; $display("FAIL front_lo%0d got %h exp %h", i, q_b, 8'(i)); end
      addr_b = 5'(2 * i + 1); tick();
      checks++; if (q_b !== 8'h10) begin errors++; $display("FAIL front_hi%0d got %h exp 10", i, q_b); end
    end
  endtask

  task automatic test_flip_deferred();
    clear_value = 16'h0A0A; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int b = 1; b <= 16; b++) begin
      flip_req = (b == 1);
      vsync    = (b == 5) || (b == 16);
      tick();
      flip_req = 1'b0; vsync = 1'b0;
      if (b >= 5) begin
        checks++; if (flip_pending !== 1'b1) begin errors++; $display("FAIL defer_pending cyc%0d got %b exp 1", b + 1, flip_pending); end
        checks++; if (flip_done !== 1'b0) begin errors++; $display("FAIL defer_done cyc%0d got %b exp 0", b + 1, flip_done); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL defer_busy got %b exp 0", busy); end
    addr_b = 5'd0; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++; if (flip_done !== 1'b1) begin errors++; $display("FAIL deferred_done got %b exp 1", flip_done); end
    checks++; if (flip_pending !== 1'b0) begin errors++; $display("FAIL deferred_pending got %b exp 0", flip_pending); end
    checks++; if (q_b !== 8'h00) begin errors++; $display("FAIL swap_cycle_q_b got %h exp 00", q_b); end
    tick();
    checks++; if (q_b !== 8'h0A) begin errors++; $display("FAIL new_front_q_b got %h exp 0a", q_b); end
  endtask

  task automatic test_clear_with_flip();
    // Front is page 0 (0x0A0A fill), back is page 1 (0x1000+i pattern).
    clear_value = 16'h0F0F; clear_req = 1'b1; flip_req = 1'b1; vsync = 1'b1;
    tick();
    clear_req = 1'b0; flip_req = 1'b0; vsync = 1'b0;
    checks++; if (flip_done !== 1'b1) begin errors++; $display("FAIL clr_flip_done got %b exp 1", flip_done); end
    for (int b = 1; b <= 16; b++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_flip_busy got %b exp 0", busy); end
    addr_a = 4'd7; tick();
    checks++; if (q_a !== 16'h0F0F) begin errors++; $display("FAIL clr_flip_back got %h exp 0f0f", q_a); end
    addr_b = 5'd6; tick();
    checks++; if (q_b !== 8'h03) begin errors++; $display("FAIL clr_flip_front_lo got %h exp 03", q_b); end
    addr_b = 5'd7; tick();
    checks++; if (q_b !== 8'h10) begin errors++; $display("FAIL clr_flip_front_hi got %h exp 10", q_b); end
  endtask

  task automatic test_reset_mid_clear();
    logic [15:0] exp;
    reset = 1'b1; tick(); reset = 1'b0;  // back page is page 1 again
    for (int i = 0; i < 16; i++) write_a(4'(i), 16'h2000 + 16'(i), 2'b11);
    clear_value = 16'hC1C1; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int b = 1; b < 5; b++) tick();
    reset = 1'b1;                        // asserted during clear cycle 5
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b exp 1", ready_a); end
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i); tick();
      exp = (i < 5) ? 16'hC1C1 : 16'h2000 + 16'(i);
      checks++; if (q_a !== exp) begin errors++; $display("FAIL partial_word%0d got %h exp %h", i, q_a, exp); end
    end
  endtask
`else
  task automatic test_clear_disabled();
    clear_value = 16'hDEAD; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nocl_busy cyc%0d got %b exp 0", b, busy); end
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL nocl_ready cyc%0d got %b exp 1", b, ready_a); end
      tick();
    end
    addr_a = 4'd5; tick();
    checks++; if (q_a !== 16'h1234) begin errors++; $display("FAIL nocl_untouched got %h exp 1234", q_a); end
    write_a(4'd2, 16'h3333, 2'b11);
    addr_a = 4'd2; tick();
    checks++; if (q_a !== 16'h3333) begin errors++; $display("FAIL nocl_write got %h exp 3333", q_a); end
  endtask
`endif

  initial begin
    reset = 1'b0; wr_a = 1'b0; mask_a = 2'b00; addr_a = '0; data_a = '0;
    addr_b = '0; flip_req = 1'b0; vsync = 1'b0; clear_req = 1'b0; clear_value = '0;
    test_reset();
    test_byte_mask();
    test_page_isolation();
    test_flip_timing();
`ifdef FB_CLEAR_EN
    test_clear();
    test_flip_deferred();
    test_clear_with_flip();
    test_reset_mid_clear();
`else
    test_clear_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
